// File: rtl/mips32i_pkg.sv
// Shared MIPS32 front-end definitions.
// Next-PC select codes and fetch FSM encoding.
package mips32i_pkg;

  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_J   = 2'b01;
  localparam logic [1:0] NPC_BEQ = 2'b10;
  localparam logic [1:0] NPC_BNE = 2'b11;

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_HOLD    = 2'd2,
    ST_RESOLVE = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/mips32i_npc.sv
// Combinational next-PC calculator.
// Shared between the simple and a future pipelined fetch.
module mips32i_npc
  import mips32i_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [1:0]  i_ctrl,
  input  logic        i_alu_zero,
  input  logic [31:0] i_imm_sext,
  input  logic [25:0] i_jump_index,
  output logic [31:0] o_npc
);

  logic [31:0] w_pc4;
  logic [31:0] w_off;
  logic [31:0] w_br;

  assign w_pc4 = i_pc + 32'd4;
  assign w_off = i_imm_sext << 2;
  assign w_br  = w_pc4 + w_off;

  always_comb begin
    o_npc = w_pc4;
    unique case (i_ctrl)
      NPC_SEQ: o_npc = w_pc4;
      NPC_J:   o_npc = {w_pc4[31:28], i_jump_index, 2'b00};
      NPC_BEQ: o_npc = i_alu_zero ? w_br : w_pc4;
      NPC_BNE: o_npc = i_alu_zero ? w_pc4 : w_br;
    endcase
  end

endmodule

// File: rtl/mips32i_fetch.sv
// Non-speculative instruction fetch stage.
// One instruction in flight; waits for resolution.
module mips32i_fetch
  import mips32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        res_valid,
  input  logic [1:0]  next_PC_ctrl,
  input  logic        alu_zero,
  input  logic [31:0] imm_sext,
  input  logic [25:0] jump_index,
  output logic [31:0] fetch_count
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_inst;
  logic [31:0]  r_inst_pc;
  logic [31:0]  r_cnt;
  logic [31:0]  w_npc;

  mips32i_npc u_npc (
    .i_pc         (r_inst_pc),
    .i_ctrl       (next_PC_ctrl),
    .i_alu_zero   (alu_zero),
    .i_imm_sext   (imm_sext),
    .i_jump_index (jump_index),
    .o_npc        (w_npc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_BOOT;
      r_pc      <= RESET_PC;
      r_inst    <= 32'd0;
      r_inst_pc <= 32'd0;
      r_cnt     <= 32'd0;
    end else begin
      unique case (r_state)
        ST_BOOT: r_state <= ST_FETCH;
        ST_FETCH: begin
          if (imem_ack) begin
            r_inst    <= imem_rdata;
            r_inst_pc <= r_pc;
            r_state   <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (inst_ready) begin
            r_cnt <= r_cnt + 32'd1;
            if (res_valid) begin
              r_pc    <= w_npc;
              r_state <= ST_FETCH;
            end else begin
              r_state <= ST_RESOLVE;
            end
          end
        end
        ST_RESOLVE: begin
          if (res_valid) begin
            r_pc    <= w_npc;
            r_state <= ST_FETCH;
          end
        end
      endcase
    end
  end

  // Handshake outputs depend on state only, never on inputs.
  assign imem_req    = (r_state == ST_FETCH);
  assign inst_valid  = (r_state == ST_HOLD);
  assign imem_addr   = r_pc;
  assign inst        = r_inst;
  assign inst_pc     = r_inst_pc;
  assign fetch_count = r_cnt;

endmodule
